// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT
// sequencer, held (one-shot) or single-cycle (auto-reload) interrupt request.
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  localparam logic [1:0] M_RELOAD = 2'b01;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic        irq_flag;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        unused_addr;

  assign ctrl_wr     = WE && (Addr[3:2] == A_CTRL);
  assign preset_wr   = WE && (Addr[3:2] == A_PRESET);
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  // Sequencer decisions use the CTRL value held before the edge; a CTRL write
  // is applied last so it overrides the INT-state Enable clear and irq_flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= IDLE;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        default: begin
          state <= IDLE;
          if (ctrl.mode == M_RELOAD) irq_flag <= 1'b0;
          else                       ctrl.en  <= 1'b0;
        end
      endcase

      if (ctrl_wr) begin
        ctrl     <= ctrl_t'(Din[3:0]);
        irq_flag <= 1'b0;
      end
      if (preset_wr) preset <= Din;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      A_CTRL:   Dout = {28'd0, ctrl};
      A_PRESET: Dout = preset;
      A_COUNT:  Dout = count;
      default:  Dout = '0;
    endcase
  end

  assign IRQ = ctrl.im & irq_flag;

endmodule

// File: tb/tb_tc_timer.sv
// Randomized + directed bench for tc_timer; a timeline reference model predicts
// Dout/IRQ after every edge and a monitor compares them from a queue.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  tc_timer dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic        irq;
    logic [1:0]  a;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: a run is described by its age (edges since leaving idle)
  // and the preset captured at load; COUNT follows from age arithmetically.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, base, frozen;
  bit          m_flag;
  longint      age;

  function automatic longint run_len();
    return (base == 0) ? 64'd1 : longint'(base);
  endfunction

  function automatic logic [31:0] cnt_now();
    longint L = run_len();
    if (age >= 2 && age <= L + 1) return 32'(longint'(base) - (age - 2));
    if (age == L + 2) return 32'd0;
    return frozen;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; base = '0; frozen = '0; m_flag = 0; age = 0;
  endtask

  task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
    longint L = run_len();
    logic   en = m_ctrl[0];
    if (age == 0) begin
      if (en) age = 1;
    end else if (age == 1) begin
      base = m_preset;
      age  = 2;
    end else if (age <= L + 1) begin
      if (!en) begin
        frozen = cnt_now();
        age    = 0;
      end else begin
        age++;
        if (age == L + 2) m_flag = 1;
      end
    end else begin
      age = 0; frozen = 0;
      if (m_ctrl[2:1] == 2'b01) m_flag = 0;
      else                      m_ctrl[0] = 1'b0;
    end
    if (we && a == 2'd0) begin m_ctrl = d[3:0]; m_flag = 0; end
    if (we && a == 2'd1) m_preset = d;
  endtask

  function automatic logic [31:0] model_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return cnt_now();
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // One bus cycle: drive at negedge, predict the post-edge outputs.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    WE   = we;
    Addr = {$urandom_range(0, 32'h0FFF_FFFF), a, 2'($urandom_range(0, 3))};
    Din  = d;
    if (reset) model_reset();
    else       model_edge(we, a, d);
    e.dout = model_dout(a);
    e.irq  = m_ctrl[3] & m_flag;
    e.a    = a;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("dout[a=%0d]", e.a), Dout, e.dout);
        chk("irq", {31'd0, IRQ}, {31'd0, e.irq});
      end
    end
  end

  initial begin : stim
    model_reset();
    // reset state on every register window
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      Addr = 32'(a) << 2;
      #1;
      chk($sformatf("rst_dout[a=%0d]", a), Dout, 32'd0);
    end
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b0;

    // one-shot, IM = 1, PRESET = 5
    cyc(1, 1, 32'd5);
    cyc(1, 0, 32'hFFFF_FFF9);
    for (int i = 0; i < 10; i++) cyc(0, 2, 0);
    for (int i = 0; i < 3; i++)  cyc(0, 0, 0);
    cyc(1, 0, 32'd0);
    cyc(0, 0, 0);

    // auto-reload, then with IM = 0
    cyc(1, 1, 32'd3);
    cyc(1, 0, 32'hB);
    for (int i = 0; i < 20; i++) cyc(0, 2, 0);
    cyc(1, 0, 32'h3);
    for (int i = 0; i < 14; i++) cyc(0, 2, 0);
    cyc(1, 0, 32'd0);

    // pause at 60, then re-enable reloads from PRESET
    cyc(1, 1, 32'd100);
    cyc(1, 0, 32'h9);
    for (int i = 0; i < 200 && cnt_now() != 32'd61; i++) cyc(0, 2, 0);
    cyc(1, 0, 32'h8);
    for (int i = 0; i < 5; i++) cyc(0, 2, 0);
    cyc(1, 0, 32'h9);
    for (int i = 0; i < 4; i++) cyc(0, 2, 0);

    // CTRL write colliding with the INT-state Enable clear
    cyc(1, 0, 32'd0);
    cyc(1, 1, 32'd2);
    cyc(1, 0, 32'h9);
    for (int i = 0; i < 20 && age != run_len() + 2; i++) cyc(0, 2, 0);
    cyc(1, 0, 32'h9);
    cyc(0, 0, 0);
    cyc(1, 0, 32'd0);

    // writes to COUNT and the spare slot change nothing
    cyc(1, 2, 32'hDEAD_BEEF);
    cyc(1, 3, 32'hCAFE_F00D);
    for (int a = 0; a < 4; a++) cyc(0, 2'(a), 0);

    // PRESET = 0 expires like PRESET = 1
    cyc(1, 1, 32'd0);
    cyc(1, 0, 32'h9);
    for (int i = 0; i < 6; i++) cyc(0, 2, 0);

    // asynchronous reset in the middle of a count
    cyc(1, 1, 32'd10);
    cyc(1, 0, 32'h9);
    for (int i = 0; i < 5; i++) cyc(0, 2, 0);
    @(negedge clk);
    WE = 1'b0; Addr = 32'h8;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", Dout, 32'd0);
    chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
    model_reset();
    cyc(0, 0, 0);
    cyc(0, 2, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 2, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] a = 2'($urandom_range(0, 3));
      logic       we = ($urandom_range(0, 9) == 0);
      logic [31:0] d = (a == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom();
      cyc(we, a, d);
    end

    WE = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
